// File: rtl/word_gen_if.sv
// word_gen_if: valid/ready word stream carrying one N-digit base-4 word per handshake.
interface word_gen_if #(parameter int N = 4);
  logic [2*N-1:0] word_out;
  logic           word_valid;
  logic           word_ready;
  modport master(output word_out, word_valid, input word_ready);
  modport slave(input word_out, word_valid, output word_ready);
endinterface

// File: rtl/word_gen.sv
// word_gen: streams every N-digit base-4 word whose digit sum equals target_sum, ascending.
// Optional WORD_GEN_ABORT_EN adds an abort input that ends a run early.
module word_gen #(parameter int N = 4) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [9:0]      target_sum,
`ifdef WORD_GEN_ABORT_EN
  input  logic            abort,
`endif
  word_gen_if.master      stream,
  output logic            busy,
  output logic            done,
  output logic [2*N:0]    match_count
);
  typedef enum logic [1:0] {IDLE, SEARCH, HOLD, DONE} state_t;
  localparam logic [9:0] MAX_SUM = 10'(3 * N);
  state_t state, state_n;
  logic [2*N-1:0] cand, cand_n, word, word_n;
  logic [9:0] target, target_n, sum;
  logic [2*N:0] count, count_n;
  logic last, hit, kill;
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + 10'(cand[2*i +: 2]);
  end
  assign last = &cand;
  assign hit = sum == target;
`ifdef WORD_GEN_ABORT_EN
  assign kill = abort && (state == SEARCH || state == HOLD);
`else
  assign kill = 1'b0;
`endif
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    target_n = target;
    word_n   = word;
    count_n  = count;
    if (kill) state_n = DONE;
    else case (state)
      IDLE: if (start) begin
        target_n = target_sum;
        cand_n   = '0;
        count_n  = '0;
        state_n  = target_sum > MAX_SUM ? DONE : SEARCH;
      end
      SEARCH: begin
        word_n  = hit ? cand : word;
        state_n = hit ? HOLD : last ? DONE : SEARCH;
        cand_n  = (hit || last) ? cand : cand + (2*N)'(1);
      end
      HOLD: if (stream.word_ready) begin
        count_n = count + (2*N+1)'(1);
        state_n = last ? DONE : SEARCH;
        cand_n  = last ? cand : cand + (2*N)'(1);
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      cand   <= '0;
      target <= '0;
      word   <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      target <= target_n;
      word   <= word_n;
      count  <= count_n;
    end
  assign stream.word_out   = word;
  assign stream.word_valid = state == HOLD;
  assign busy              = state != IDLE;
  assign done              = state == DONE;
  assign match_count       = count;
endmodule

// File: tb/tb_word_gen.sv
// tb_word_gen: randomized runs of word_gen checked against a digit-sum enumeration model.
module tb_word_gen;
  logic clk = 0, rst = 1;
  logic start_a = 0, start_b = 0, abort_a = 0, abort_b = 0;
  logic [9:0] tsum_a = 0, tsum_b = 0;
  logic busy_a, done_a, busy_b, done_b;
  logic [4:0] cnt_a;
  logic [8:0] cnt_b;
  int cyc = 0, checks = 0, failures = 0;
  int acc = 0, hb = 0, aborted = 0;
  longint words = 0;
  logic [3:0] exp_q[$];
  logic [7:0] last_b;

  word_gen_if #(.N(2)) ia();
  word_gen_if #(.N(4)) ib();

  word_gen #(.N(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .target_sum(tsum_a),
`ifdef WORD_GEN_ABORT_EN
    .abort(abort_a),
`endif
    .stream(ia), .busy(busy_a), .done(done_a), .match_count(cnt_a));

  word_gen #(.N(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .target_sum(tsum_b),
`ifdef WORD_GEN_ABORT_EN
    .abort(abort_b),
`endif
    .stream(ib), .busy(busy_b), .done(done_b), .match_count(cnt_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dsum(input int w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) begin
      s += w % 4;
      w /= 4;
    end
    return s;
  endfunction

  // Model: the pending queue front is the only word allowed on the bus until it is accepted.
  always @(negedge clk) if (!rst) begin
    if (ia.word_valid) begin
      check("have_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("word_out", ia.word_out, exp_q[0]);
        if (ia.word_ready && !abort_a) begin
          words = (words << 4) | longint'(ia.word_out);
          acc++;
          void'(exp_q.pop_front());
        end
      end
      if (abort_a) aborted = 1;
    end
    if (done_a) begin
      check("done_count", cnt_a, acc);
      if (aborted == 0) check("leftover", exp_q.size(), 0);
    end
  end

  always @(negedge clk) if (!rst && ib.word_valid && ib.word_ready) begin
    hb++;
    check("b_sum", dsum(int'(ib.word_out), 4), 6);
    if (hb > 1) check("b_order", 64'(ib.word_out > last_b), 1);
    last_b = ib.word_out;
  end

  task automatic run_a(input int t, input int mode, input int lit_m, input longint lit_words);
    int s, d, fv, m, first_c, hold, busy_n, ab_cyc;
    bit got_done, ab_done;
    exp_q.delete();
    for (int w = 0; w < 16; w++) if (dsum(w, 2) == t) exp_q.push_back(4'(w));
    m = exp_q.size();
    first_c = m > 0 ? int'(exp_q[0]) : 0;
    if (lit_m >= 0) check("model_count", m, lit_m);
    acc = 0; words = 0; aborted = 0; fv = -1; hold = 0; busy_n = 0;
    got_done = 0; ab_done = 0; ab_cyc = -10; d = 0;
    @(posedge clk); #1;
    start_a = 1; tsum_a = 10'(t); s = cyc;
    @(posedge clk); #1;
    start_a = 0;
    for (int g = 0; g < 2000 && !got_done; g++) begin
      abort_a = 0;
      if (mode == 1) begin
        ia.word_ready = ia.word_valid && hold >= 5;
        hold = ia.word_valid ? hold + 1 : 0;
      end else if (mode == 2) ia.word_ready = 1'($urandom_range(0, 1));
      else ia.word_ready = 1;
      if (mode == 3 && !ab_done && ia.word_valid && ia.word_out == 4'h6) begin
        abort_a = 1; ab_done = 1; ab_cyc = cyc;
      end
      start_a = ($urandom_range(0, 3) == 0);
      tsum_a = 10'($urandom_range(0, 9));
      @(negedge clk);
      if (busy_a) busy_n++;
      if (fv < 0 && ia.word_valid) fv = cyc;
      if (done_a) begin
        got_done = 1; d = cyc; start_a = 0;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", got_done, 1);
    if (mode != 3) check("match_count", cnt_a, m);
    if (lit_words >= 0) check("word_seq", words, lit_words);
    if (mode == 0) begin
      check("run_cycles", d - s + 1, t > 6 ? 2 : 16 + m + 2);
      check("busy_cycles", busy_n, t > 6 ? 1 : 16 + m + 1);
      if (m > 0) check("first_valid", fv, s + first_c + 2);
    end
    if (mode == 3) begin
      check("abort_count", cnt_a, 1);
      check("abort_done", d, ab_cyc + 1);
    end
    @(posedge clk); #1;
    ia.word_ready = 0; abort_a = 0;
    @(negedge clk);
    check("done_pulse", done_a, 0);
    check("idle", busy_a, 0);
  endtask

  initial begin
    int mb;
    bit seen;
    ia.word_ready = 0;
    ib.word_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word", ia.word_out, 0);
    check("rst_valid", ia.word_valid, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_count", cnt_a, 0);
    rst = 0;
    run_a(3, 0, 4, 64'h369C);
    run_a(0, 0, 1, 64'h0);
    run_a(6, 0, 1, 64'hF);
    run_a(7, 0, 0, 0);
    run_a(3, 1, 4, 64'h369C);
    for (int r = 0; r < 8; r++) run_a($urandom_range(0, 8), $urandom_range(0, 2), -1, -1);
`ifdef WORD_GEN_ABORT_EN
    run_a(3, 3, 4, 64'h3);
`endif
    mb = 0;
    for (int w = 0; w < 256; w++) if (dsum(w, 4) == 6) mb++;
    check("model_b_count", mb, 44);
    hb = 0;
    @(posedge clk); #1;
    ib.word_ready = 1; start_b = 1; tsum_b = 10'd6;
    @(posedge clk); #1;
    start_b = 0;
    for (int g = 0; g < 600 && hb < 2; g++) @(negedge clk);
    @(posedge clk); #1;
    ib.word_ready = 0;
    seen = 0;
    for (int g = 0; g < 600 && !seen; g++) begin
      @(negedge clk);
      seen = ib.word_valid;
    end
    check("b_third_pending", seen, 1);
    check("b_pre_accepts", hb, 2);
    #2 rst = 1;
    #1;
    check("b_rst_valid", ib.word_valid, 0);
    check("b_rst_word", ib.word_out, 0);
    check("b_rst_busy", busy_b, 0);
    check("b_rst_done", done_b, 0);
    check("b_rst_count", cnt_b, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("b_no_done", done_b, 0);
      check("b_stay_idle", busy_b, 0);
    end
    hb = 0;
    @(posedge clk); #1;
    ib.word_ready = 1; start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    seen = 0;
    for (int g = 0; g < 800 && !seen; g++) begin
      @(negedge clk);
      seen = done_b;
    end
    check("b_done_seen", seen, 1);
    check("b_count", cnt_b, 44);
    check("b_handshakes", hb, 44);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/word_gen.md
Name: word_gen

Overview:
- Inverse of the word digit-sum block: given a target sum, enumerates every N-digit base-4 word (2 bits per digit) whose digit sum equals the target.
- Streams matching words out over a valid/ready handshake in ascending numeric order, then pulses done.
- Sits upstream of the word pipeline as a stimulus/candidate source for sum-constrained DNA word sets.

Parameters:
- N, 4, number of 2-bit digits per word (1..8); max digit sum 3N fits in 10 bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin enumeration; sampled only in IDLE
- target_sum  input  10  required digit sum; latched on accepted start
- word_out  output  2N  current matching word; digit i = word_out[2i+1:2i]
- word_valid  output  1  word_out holds a match
- word_ready  input  1  consumer accepts word_out when word_valid && word_ready
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at end of enumeration
- match_count  output  2N+1  number of words accepted in current/last run

Behaviour:
- Reset (async): state=IDLE, candidate=0, target=0, word_out=0, word_valid=0, done=0, match_count=0.
- State register holds IDLE, SEARCH, HOLD or DONE.
- IDLE:
  - start=1: latch target_sum, candidate=0, match_count=0.
  - If target_sum > 3N, next state is DONE (no words emitted). Otherwise next state is SEARCH.
  - start with target_sum=0 is legal.
- SEARCH: evaluate one candidate per cycle. digit_sum(candidate) is combinational; add zero-extended 2-bit digits in 10-bit width.
  - Match: register word_out=candidate, word_valid=1, go to HOLD.
  - No match, candidate = all-ones (4^N-1): go to DONE.
  - No match otherwise: candidate+1, stay in SEARCH.
- HOLD: word_valid=1; word_out is stable until accepted.
  - word_ready=1: word_valid=0 next cycle and match_count+1. Then go to DONE if candidate = all-ones; otherwise candidate+1 and go to SEARCH.
  - word_ready=0: hold indefinitely, nothing changes.
- DONE: done=1 for exactly this cycle, then IDLE. word_out keeps the last emitted value; match_count holds until the next accepted start.
- Timing:
  - Throughput: at most one word per 2 cycles (SEARCH then HOLD).
  - Latency: start at edge k gives the first match at candidate c with word_valid high from edge k+c+2.
  - A run with zero backpressure takes 4^N + (matches) + 2 cycles, start to done.
- start while busy: ignored, no effect.
- Candidate counter is 2N bits and never wraps; the termination check prevents the overflow increment.
- rst mid-operation: immediate return to reset values. A word that is valid but not yet accepted is dropped; no done pulse.
- word_ready while word_valid=0: ignored.

Optional Feature:
- Macro: WORD_GEN_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 in SEARCH or HOLD: next cycle goes to DONE with word_valid=0. A pending unaccepted word is dropped and not counted.
  - done pulses as normal; match_count keeps the words accepted so far.
  - abort in IDLE or DONE: ignored. abort has priority over word_ready in the same cycle.
- Not defined: no abort port; an enumeration always runs to completion.

Test Plan:
- N=2, target_sum=3, word_ready=1 -> words 0x3,0x6,0x9,0xC in order; done once; match_count=4; exactly 4 valid/ready handshakes.
- N=2, target_sum=0 then target_sum=6 -> runs emit only 0x0 and only 0xF respectively; match_count=1 each.
- N=2, target_sum=7 -> busy high one cycle, done pulses the cycle after start; word_valid never asserts; match_count=0.
- N=2, target_sum=3, word_ready held low 5 cycles on each word -> word_out stable at 0x3 throughout stall; same final sequence and count as the no-stall run; start pulses while busy have no effect.
- N=4, target_sum=6, rst asserted while in HOLD at third word -> all outputs reset immediately; no done. A new start gives a full run with match_count=44.
- WORD_GEN_ABORT_EN defined, N=2, target_sum=3: abort while 0x6 is pending in HOLD with word_ready=1 -> 0x6 not accepted; done next cycle; match_count=1.
